// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit codes, packing constants and the unpacker FSM states.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b10;

  localparam int         TRITS_PER_BYTE = 5;
  localparam logic [7:0] PACK_MAX       = 8'd242;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } unpack_state_e;

endpackage

// File: rtl/trit_byte_decode.sv
// Combinational base-3 unpack of one byte into five balanced trits.
// Bytes above PACK_MAX decode as all-zero trits and raise invalid_o.
module trit_byte_decode
  import ternary_pkg::*;
(
  input  logic [7:0]                  byte_i,
  output logic [2*TRITS_PER_BYTE-1:0] trits_o,
  output logic                        invalid_o
);

  always_comb begin
    logic [7:0] v;
    logic [7:0] q;
    logic [7:0] r;
    trits_o   = '0;
    invalid_o = (byte_i > PACK_MAX);
    v         = byte_i;
    // Successive divide-by-3; each remainder is the next digit, lowest lane first.
    for (int i = 0; i < TRITS_PER_BYTE; i++) begin
      q = v / 8'd3;
      r = v - q * 8'd3;
      case (r)
        8'd1:    trits_o[2*i +: 2] = TRIT_POS;
        8'd2:    trits_o[2*i +: 2] = TRIT_NEG;
        default: trits_o[2*i +: 2] = TRIT_ZERO;
      endcase
      v = q;
    end
    if (invalid_o) trits_o = '0;
  end

endmodule

// File: rtl/trit_lane_unpacker.sv
// Assembles LANE_COUNT/5 packed bytes into one lane vector of balanced trits.
// Optional vec_count output when TRIT_UNPACK_STATS_EN is defined.
module trit_lane_unpacker
  import ternary_pkg::*;
#(
  parameter int LANE_COUNT = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_byte,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*LANE_COUNT-1:0] out_trits,
  output logic                    out_last,
  output logic                    out_short,
`ifdef TRIT_UNPACK_STATS_EN
  output logic [15:0]             vec_count,
`endif
  output logic                    err_invalid,
  input  logic                    err_clear
);

  localparam int BPV   = LANE_COUNT / TRITS_PER_BYTE;
  localparam int IDX_W = (BPV > 1) ? $clog2(BPV) : 1;
  localparam int VEC_W = 2 * LANE_COUNT;
  localparam int GRP_W = 2 * TRITS_PER_BYTE;

  unpack_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] asm_q, asm_d;
  logic [VEC_W-1:0] trits_q, trits_d;
  logic             last_q, last_d;
  logic             short_q, short_d;
  logic             err_q, err_d;
  logic [VEC_W-1:0] merged;
  logic [GRP_W-1:0] dec_trits;
  logic             dec_invalid;
  logic             in_fire, pop, complete;

  trit_byte_decode u_decode (
    .byte_i    (in_byte),
    .trits_o   (dec_trits),
    .invalid_o (dec_invalid)
  );

  assign in_ready  = (state_q == COLLECT) || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign pop       = (state_q == EMIT) && out_ready;
  assign complete  = in_last || (idx_q == IDX_W'(BPV - 1));
  assign out_valid = (state_q == EMIT);
  assign out_trits = trits_q;
  assign out_last  = last_q;
  assign out_short = short_q;
  assign err_invalid = err_q;

  always_comb begin
    merged = asm_q;
    for (int g = 0; g < BPV; g++) begin
      if (IDX_W'(g) == idx_q) merged[g*GRP_W +: GRP_W] = dec_trits;
    end

    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    trits_d = trits_q;
    last_d  = last_q;
    short_d = short_q;

    // In EMIT idx_q is 0 and asm_q is clear, so an overlapped byte lands in group 0.
    if (in_fire) begin
      if (complete) begin
        state_d = EMIT;
        idx_d   = '0;
        asm_d   = '0;
        trits_d = merged;
        last_d  = in_last;
        short_d = in_last && (idx_q != IDX_W'(BPV - 1));
      end else begin
        state_d = COLLECT;
        idx_d   = idx_q + IDX_W'(1);
        asm_d   = merged;
      end
    end else if (pop) begin
      state_d = COLLECT;
      idx_d   = '0;
      asm_d   = '0;
    end

    err_d = err_clear ? 1'b0 : err_q;
    if (in_fire && dec_invalid) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      asm_q   <= '0;
      trits_q <= '0;
      last_q  <= 1'b0;
      short_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      trits_q <= trits_d;
      last_q  <= last_d;
      short_q <= short_d;
      err_q   <= err_d;
    end
  end

`ifdef TRIT_UNPACK_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_clear)                    cnt_d = '0;
    else if (pop && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign vec_count = cnt_q;
`endif

endmodule

// File: tb/tb_trit_lane_unpacker.sv
// Scoreboard bench for trit_lane_unpacker with LANE_COUNT=15 (3 bytes per vector).
module tb_trit_lane_unpacker;

  localparam int LC  = 15;
  localparam int BPV = LC / 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_last;
  logic [7:0]    in_byte;
  logic          out_valid, out_ready, out_last, out_short;
  logic [2*LC-1:0] out_trits;
  logic          err_invalid, err_clear;
`ifdef TRIT_UNPACK_STATS_EN
  logic [15:0]   vec_count;
`endif

  trit_lane_unpacker #(.LANE_COUNT(LC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_trits   (out_trits),
    .out_last    (out_last),
    .out_short   (out_short),
`ifdef TRIT_UNPACK_STATS_EN
    .vec_count   (vec_count),
`endif
    .err_invalid (err_invalid),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*LC-1:0] t;
    logic            l;
    logic            s;
  } exp_t;

  exp_t            sb[$];
  int              pop_cycles[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  logic [2*LC-1:0] m_asm = '0;
  logic [2*LC-1:0] m_last_vec = '0;
  int              m_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ref_decode(input int b);
    logic [9:0] r;
    int p;
    int d;
    r = '0;
    p = 1;
    if (b > 242) return r;
    for (int i = 0; i < 5; i++) begin
      d = (b / p) % 3;
      r[2*i +: 2] = (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b00;
      p = p * 3;
    end
    return r;
  endfunction

  task automatic model_accept(input logic [7:0] b, input logic l);
    exp_t e;
    m_asm[10*m_idx +: 10] = ref_decode(int'(b));
    if (l || m_idx == BPV - 1) begin
      e.t = m_asm;
      e.l = l;
      e.s = l && (m_idx < BPV - 1);
      sb.push_back(e);
      m_last_vec = m_asm;
      m_asm = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Drive one byte starting just after a rising edge; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] b, input logic l);
    bit done = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = l;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(b, l);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      pop_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_vec", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("vec_trits", 64'(out_trits), 64'(e.t));
        chk("vec_last", 64'(out_last), 64'(e.l));
        chk("vec_short", 64'(out_short), 64'(e.s));
      end
    end
  end

  initial begin
    logic [2*LC-1:0] k;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    err_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_trits", 64'(out_trits), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_short", 64'(out_short), 64'd0);
    chk("rst_err", 64'(err_invalid), 64'd0);
    reset_n = 1'b1;
    idle(1);

    // Bytes 0, 242, 5 -> known lane pattern, one cycle latency.
    send(8'd0, 1'b0);
    send(8'd242, 1'b0);
    chk("lat_before", 64'(out_valid), 64'd0);
    send(8'd5, 1'b0);
    k = '0;
    for (int i = 5; i < 10; i++) k[2*i +: 2] = 2'b10;
    k[21:20] = 2'b10;
    k[23:22] = 2'b01;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("t1_trits", 64'(out_trits), 64'(k));
    idle(2);

    // Invalid byte handling and err_clear precedence.
    send(8'd243, 1'b0);
    chk("err_set", 64'(err_invalid), 64'd1);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    idle(2);
    chk("err_sticky", 64'(err_invalid), 64'd1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    chk("err_cleared", 64'(err_invalid), 64'd0);
    err_clear = 1'b1;
    send(8'd250, 1'b0);
    err_clear = 1'b0;
    chk("err_set_wins", 64'(err_invalid), 64'd1);
    send(8'd100, 1'b0);
    send(8'd200, 1'b0);
    idle(2);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;

    // Early in_last: short, zero-padded vector.
    send(8'd1, 1'b1);
    chk("short_trits", 64'(out_trits), 64'd1);
    chk("short_last", 64'(out_last), 64'd1);
    chk("short_flag", 64'(out_short), 64'd1);
    idle(2);

    // Backpressure: hold for 4 cycles, then release with an overlapped byte.
    out_ready = 1'b0;
    send(8'd7, 1'b0);
    send(8'd100, 1'b0);
    send(8'd200, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_trits", 64'(out_trits), 64'(m_last_vec));
      idle(1);
    end
    out_ready = 1'b1;
    send(8'd42, 1'b0);
    send(8'd81, 1'b0);
    send(8'd121, 1'b1);
    idle(3);

    // Six back-to-back bytes: two vectors exactly BPV cycles apart.
    pop_cycles.delete();
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b0);
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    idle(3);
    chk("b2b_count", 64'(pop_cycles.size()), 64'd2);
    if (pop_cycles.size() == 2)
      chk("b2b_spacing", 64'(pop_cycles[1] - pop_cycles[0]), 64'(BPV));

    // Reset mid-vector discards the partial assembly.
    send(8'd242, 1'b0);
    send(8'd242, 1'b0);
    reset_n = 1'b0;
    m_asm = '0;
    m_idx = 0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send(8'd1, 1'b0);
    send(8'd3, 1'b0);
    send(8'd9, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_last", 64'(out_last), 64'd0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trit_lane_unpacker.md
# trit_lane_unpacker

Sits directly downstream of the frame controller's memory fetch path. It takes the packed ternary byte stream read at the controller-generated addresses and produces one full lane vector of balanced trits per handshake for the ternary engine. Each byte carries 5 trits in base-3 (value 0..242). `LANE_COUNT/5` bytes form one vector, which is the controller's per-step stride.

## Interface
- `LANE_COUNT`, default 15: lanes per vector; must be a nonzero multiple of 5.
- `BPV` (localparam) = `LANE_COUNT/5`: bytes per vector.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: unpacker accepts a byte.
- `in_byte` in 8: packed byte, 5 trits.
- `in_last` in 1: final byte of the frame.
- `out_valid` out 1: lane vector valid.
- `out_ready` in 1: engine accepts the vector.
- `out_trits` out 2*LANE_COUNT: lane i occupies bits [2i+1:2i]. Codes: 00=0, 01=+1, 10=-1.
- `out_last` out 1: vector contains the frame's last byte.
- `out_short` out 1: vector was zero-padded because of an early `in_last`.
- `err_invalid` out 1: sticky; a byte >242 was seen.
- `err_clear` in 1: synchronous clear of `err_invalid` (and the stats counter).

## Operation
- States: COLLECT, EMIT.
- COLLECT:
  - `in_ready`=1.
  - On each input transfer, decode `in_byte` into lanes `5*byte_idx .. 5*byte_idx+4`. The least-significant base-3 digit goes to the lowest lane.
  - Digit mapping: 0→0, 1→+1, 2→-1.
- Transition to EMIT when the accepted byte has `byte_idx==BPV-1` or `in_last`=1.
  - On `in_last` with `byte_idx<BPV-1`: remaining lanes are forced to 00, and `out_short`=1.
  - `out_last` takes the value of `in_last`.
  - `byte_idx` returns to 0.
- EMIT:
  - `out_valid`=1. `out_trits`, `out_last` and `out_short` are held stable until `out_ready`.
  - `in_ready` = `out_ready`.
  - On pop with a simultaneous input transfer, the byte is written as lane group 0 of the next vector. State becomes COLLECT, or stays EMIT if `BPV`==1.
  - On pop without input, go to COLLECT and clear the assembly register.
- Invalid bytes (243..255): decode as five 0 trits and set `err_invalid`.
  - If `err_clear` and an invalid byte land in the same cycle, set wins.
- `byte_idx` width is `$clog2(BPV)` with a minimum of 1. It never exceeds `BPV-1`.
- Reset mid-vector discards the partial assembly; no vector is emitted.

## Timing
- Reset values:
  - `in_ready`=1 (COLLECT).
  - `out_valid`=0.
  - `out_trits`=0.
  - `out_last`=0, `out_short`=0.
  - `err_invalid`=0.
  - `byte_idx`=0.
- Latency: the accepted completing byte produces `out_valid`=1 on the next cycle.
- Steady-state throughput with `out_ready`=1: one vector per `BPV` cycles. No bubble, because of the overlap in EMIT.
- All outputs are registered. `in_ready` is combinational from state and `out_ready`.
- A transfer occurs only when valid and ready are both 1 at the rising edge.

## Configuration
- `TRIT_UNPACK_STATS_EN` defined:
  - Adds output `vec_count` (16 bits): counts emitted vectors (pops).
  - Saturates at 16'hFFFF.
  - Cleared by reset or `err_clear`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `ternary_pkg`:
  - Trit code constants `TRIT_ZERO`, `TRIT_POS`, `TRIT_NEG`.
  - `TRITS_PER_BYTE`=5.
  - `PACK_MAX`=242.
  - Typedef for a 2-bit trit.
- Sub-module `trit_byte_decode`: purely combinational. Takes 8-bit input; outputs 10-bit trits and an `invalid` flag. Implemented as a divide-by-3 chain or LUT.
- The top holds the FSM, assembly register, output register and flags.

## Test plan
- `LANE_COUNT`=15, bytes 0, 242, 5, no `in_last`, `out_ready`=1 → one vector:
  - lanes 0-4 = 0.
  - lanes 5-9 = -1 (10).
  - lane 10 = -1, lane 11 = +1, lanes 12-14 = 0.
  - `out_valid` rises 1 cycle after the third byte.
- Byte 243 → lanes decoded 0 and `err_invalid`=1. It stays set until `err_clear` pulses, then reads 0. When pulsed concurrently with another invalid byte, it stays 1.
- Single byte 1 with `in_last`=1 → lane 0 = +1, lanes 1-14 = 0, `out_last`=1, `out_short`=1.
- `out_ready` held 0 for 4 cycles during EMIT → `out_trits` stable and `in_ready`=0. On release, a byte presented the same cycle is captured as lanes 0-4 of the next vector.
- 6 back-to-back bytes with `out_ready`=1 → 2 vectors, spaced exactly 3 cycles apart.
- `reset_n` asserted after 2 of 3 bytes → `out_valid`=0 immediately. The next 3 bytes form a clean vector with no residue.
